// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller/datapath signal bundle for multicycle_control
interface multicycle_control_if;
  logic [5:0] i_op;
  logic       i_zero;
  logic       i_memReady;
  logic       o_pcWrite;
  logic       o_pcEn;
  logic       o_irWrite;
  logic       o_regWrite;
  logic       o_memWrite;
  logic       o_memRead;
  logic       o_iOrD;
  logic       o_aluSrcA;
  logic       o_regDst;
  logic       o_memToReg;
  logic       o_branch;
  logic [1:0] o_aluSrcB;
  logic [1:0] o_aluOp;
  logic [1:0] o_pcSrc;
  logic       o_illegal;
  logic [3:0] o_state;

  modport master (
    input  i_op, i_zero, i_memReady,
    output o_pcWrite, o_pcEn, o_irWrite, o_regWrite, o_memWrite, o_memRead,
    output o_iOrD, o_aluSrcA, o_regDst, o_memToReg, o_branch,
    output o_aluSrcB, o_aluOp, o_pcSrc, o_illegal, o_state
  );

  modport slave (
    output i_op, i_zero, i_memReady,
    input  o_pcWrite, o_pcEn, o_irWrite, o_regWrite, o_memWrite, o_memRead,
    input  o_iOrD, o_aluSrcA, o_regDst, o_memToReg, o_branch,
    input  o_aluSrcB, o_aluOp, o_pcSrc, o_illegal, o_state
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control sequencer
// Define MC_CTRL_BNE_EN to decode opcode 000101 (bne) as a branch.
module multicycle_control (
  input  logic                 i_clk,
  input  logic                 i_rstN,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

`ifdef MC_CTRL_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  state_t state, next_state, cur;
  logic   is_bne;
  logic   pc_write, ir_write, reg_write, mem_write, mem_read, illegal;

  assign is_bne = BNE_EN && (bus.i_op == OP_BNE);

  always_ff @(posedge i_clk) begin
    if (!i_rstN) state <= S_FETCH;
    else         state <= next_state;
  end

  always_comb begin
    // While reset is held the outputs present FETCH with every strobe masked.
    cur            = i_rstN ? state : S_FETCH;
    next_state     = S_FETCH;
    pc_write       = 1'b0;
    ir_write       = 1'b0;
    reg_write      = 1'b0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    illegal        = 1'b0;
    bus.o_iOrD     = 1'b0;
    bus.o_aluSrcA  = 1'b0;
    bus.o_regDst   = 1'b0;
    bus.o_memToReg = 1'b0;
    bus.o_branch   = 1'b0;
    bus.o_aluSrcB  = 2'b00;
    bus.o_aluOp    = 2'b00;
    bus.o_pcSrc    = 2'b00;
    case (cur)
      S_FETCH: begin
        mem_read      = 1'b1;
        bus.o_aluSrcB = 2'b01;
        ir_write      = bus.i_memReady;
        pc_write      = bus.i_memReady;
        next_state    = bus.i_memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.o_aluSrcB = 2'b11;
        case (bus.i_op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default: begin
            if (is_bne) next_state = S_BRANCH;
            else        illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        bus.o_aluSrcA = 1'b1;
        bus.o_aluSrcB = 2'b10;
        if (cur == S_ADDIEX)          next_state = S_ADDIWB;
        else if (bus.i_op == OP_LW)   next_state = S_MEMRD;
        else                          next_state = S_MEMWR;
      end
      S_MEMRD: begin
        bus.o_iOrD = 1'b1;
        mem_read   = 1'b1;
        next_state = bus.i_memReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.o_memToReg = 1'b1;
        reg_write      = 1'b1;
      end
      S_MEMWR: begin
        bus.o_iOrD = 1'b1;
        mem_write  = 1'b1;
        next_state = bus.i_memReady ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        bus.o_aluSrcA = 1'b1;
        bus.o_aluOp   = 2'b10;
        next_state    = S_ALUWB;
      end
      S_ALUWB: begin
        bus.o_regDst = 1'b1;
        reg_write    = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        bus.o_aluSrcA = 1'b1;
        bus.o_aluOp   = 2'b01;
        bus.o_pcSrc   = 2'b01;
        bus.o_branch  = 1'b1;
      end
      S_JUMP: begin
        bus.o_pcSrc = 2'b10;
        pc_write    = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  assign bus.o_pcWrite  = pc_write  & i_rstN;
  assign bus.o_irWrite  = ir_write  & i_rstN;
  assign bus.o_regWrite = reg_write & i_rstN;
  assign bus.o_memWrite = mem_write & i_rstN;
  assign bus.o_memRead  = mem_read  & i_rstN;
  assign bus.o_illegal  = illegal   & i_rstN;
  assign bus.o_pcEn     = (pc_write | (bus.o_branch & (bus.i_zero ^ is_bne))) & i_rstN;
  assign bus.o_state    = cur;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  multicycle_control_if bus();
  multicycle_control dut (.i_clk(clk), .i_rstN(rstn), .bus(bus));

`ifdef MC_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_BAD = 6'b111111;

  typedef struct packed {
    logic pcw, pce, irw, rw, mw, mr, iord, srca, regdst, m2r, br, ill;
    logic [1:0] srcb, aluop, pcsrc;
    logic [3:0] st;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    bit         zero;
    int         cycles;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic outs_t actual();
    outs_t o;
    o.pcw = bus.o_pcWrite;  o.pce = bus.o_pcEn;      o.irw = bus.o_irWrite;
    o.rw = bus.o_regWrite;  o.mw = bus.o_memWrite;   o.mr = bus.o_memRead;
    o.iord = bus.o_iOrD;    o.srca = bus.o_aluSrcA;  o.regdst = bus.o_regDst;
    o.m2r = bus.o_memToReg; o.br = bus.o_branch;     o.ill = bus.o_illegal;
    o.srcb = bus.o_aluSrcB; o.aluop = bus.o_aluOp;   o.pcsrc = bus.o_pcSrc;
    o.st = bus.o_state;
    return o;
  endfunction

  function automatic outs_t reset_outs();
    outs_t o = '0;
    o.srcb = 2'b01;
    return o;
  endfunction

  // Per-step datapath controls, straight from the step descriptions.
  function automatic outs_t expect_outs(input int st, input bit rdy, input bit zero,
                                        input bit bne, input bit ill);
    outs_t o = '0;
    case (st)
      0:    begin o.mr = 1; o.srcb = 2'b01; o.irw = rdy; o.pcw = rdy; end
      1:    begin o.srcb = 2'b11; o.ill = ill; end
      2, 9: begin o.srca = 1; o.srcb = 2'b10; end
      3:    begin o.iord = 1; o.mr = 1; end
      4:    begin o.m2r = 1; o.rw = 1; end
      5:    begin o.iord = 1; o.mw = 1; end
      6:    begin o.srca = 1; o.aluop = 2'b10; end
      7:    begin o.regdst = 1; o.rw = 1; end
      8:    begin o.srca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.br = 1; end
      10:   o.rw = 1;
      11:   begin o.pcsrc = 2'b10; o.pcw = 1; end
      default: ;
    endcase
    o.pce = o.pcw | (o.br & (zero ^ bne));
    o.st  = 4'(st);
    return o;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}) || (BNE_EN && op == OP_BNE);
  endfunction

  // Runs one instruction; the model is the ordered list of steps the opcode walks.
  task automatic run_instr(input logic [5:0] op, input bit zero, input int fstall,
                           input int mstall, input bit rnd, output int cycles, output int mw_cycles);
    int q[$];
    int waited;
    bit rdy, wait_step, bne, ill;
    bne = BNE_EN && (op == OP_BNE);
    ill = !is_legal(op);
    q = '{0, 1};
    if (!ill) begin
      case (op)
        OP_R:    q = '{0, 1, 6, 7};
        OP_LW:   q = '{0, 1, 2, 3, 4};
        OP_SW:   q = '{0, 1, 2, 5};
        OP_ADDI: q = '{0, 1, 9, 10};
        OP_J:    q = '{0, 1, 11};
        default: q = '{0, 1, 8};
      endcase
    end
    cycles = 0; waited = 0; mw_cycles = 0;
    while (q.size() > 0) begin
      if (cycles >= 200) begin
        check("instr_timeout", 32'(cycles), 32'd200 - 32'd1);
        break;
      end
      @(negedge clk);
      if (cycles == 0) begin
        bus.i_op = op;
        bus.i_zero = zero;
      end
      wait_step = (q[0] == 0 || q[0] == 3 || q[0] == 5);
      if (!wait_step) rdy = 1'($urandom_range(0, 1));
      else if (rnd)   rdy = ($urandom_range(0, 2) != 0);
      else            rdy = (waited >= ((q[0] == 0) ? fstall : mstall));
      bus.i_memReady = rdy;
      #1;
      check($sformatf("op%b_step%0d", op, q[0]), 32'(actual()),
            32'(expect_outs(q[0], rdy, zero, bne, ill && q[0] == 1)));
      if (bus.o_memWrite) mw_cycles++;
      cycles++;
      if (wait_step && !rdy) waited++;
      else begin
        void'(q.pop_front());
        waited = 0;
      end
    end
  endtask

  vec_t tbl[9];
  logic [5:0] pool[8];
  int cyc, mw;

  initial begin
    tbl[0] = '{OP_R, 1'b0, 4};
    tbl[1] = '{OP_LW, 1'b0, 5};
    tbl[2] = '{OP_SW, 1'b0, 4};
    tbl[3] = '{OP_BEQ, 1'b1, 3};
    tbl[4] = '{OP_BEQ, 1'b0, 3};
    tbl[5] = '{OP_ADDI, 1'b0, 4};
    tbl[6] = '{OP_J, 1'b0, 3};
    tbl[7] = '{OP_BNE, 1'b0, BNE_EN ? 3 : 2};
    tbl[8] = '{OP_BAD, 1'b1, 2};
    pool = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE, OP_BAD};

    rstn = 1'b0; bus.i_op = OP_R; bus.i_zero = 1'b0; bus.i_memReady = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      check("reset_outs", 32'(actual()), 32'(reset_outs()));
    end
    @(negedge clk);
    rstn = 1'b1; bus.i_memReady = 1'b0;
    #1;
    check("post_reset_fetch", 32'(actual()), 32'(expect_outs(0, 1'b0, 1'b0, 1'b0, 1'b0)));

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].zero, 0, 0, 1'b0, cyc, mw);
      check($sformatf("cpi_op%b", tbl[i].op), 32'(cyc), 32'(tbl[i].cycles));
    end

    run_instr(OP_SW, 1'b0, 0, 2, 1'b0, cyc, mw);
    check("sw_stall_memwrite_cycles", 32'(mw), 32'd3);
    check("sw_stall_cycles", 32'(cyc), 32'd6);
    run_instr(OP_R, 1'b0, 4, 0, 1'b0, cyc, mw);
    check("fetch_stall_cycles", 32'(cyc), 32'd8);
    run_instr(OP_LW, 1'b1, 1, 3, 1'b0, cyc, mw);
    check("lw_stall_cycles", 32'(cyc), 32'd9);

    // Reset while stalled in MEMWR.
    @(negedge clk); bus.i_op = OP_SW; bus.i_memReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.i_memReady = 1'b0; #1;
    check("memwr_stalled", 32'(actual()), 32'(expect_outs(5, 1'b0, 1'b0, 1'b0, 1'b0)));
    repeat (3) begin
      @(negedge clk); rstn = 1'b0; #1;
      check("reset_in_memwr", 32'(actual()), 32'(reset_outs()));
    end
    @(negedge clk); rstn = 1'b1; #1;
    check("release_fetch", 32'(actual()), 32'(expect_outs(0, 1'b0, 1'b0, 1'b0, 1'b0)));

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      op = pool[$urandom_range(0, 7)];
      if (op == OP_BAD) op = 6'($urandom);
      run_instr(op, 1'($urandom_range(0, 1)), 0, 0, 1'b1, cyc, mw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
